// File: rtl/aes_pkg.sv
// Shared definitions for the AES MixColumns datapath: mode encoding,
// engine FSM states and the GF(2^8) doubling helper.
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Low byte of the AES field polynomial x^8+x^4+x^3+x+1.
  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mix_state_t;

  // Multiply by x (i.e. by 2) in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mixcol_column.sv
// Combinational single-column MixColumns / InvMixColumns transform.
// Byte a is the MSB of the 32-bit column.
module aes_mixcol_column
  import aes_pkg::*;
(
  input  logic        mode,
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] s  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m3 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [31:0] fwd_col;
  logic [31:0] inv_col;

  // Per-byte multiples; the inverse coefficients all decompose into x, 2x, 4x, 8x.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s[i]  = col_in[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m3[i] = x2[i] ^ s[i];
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  // Circulant matrix rows {02,03,01,01} and {0e,0b,0d,09}, rotated per output byte.
  always_comb begin
    fwd_col = {x2[0] ^ m3[1] ^ s[2]  ^ s[3],
               s[0]  ^ x2[1] ^ m3[2] ^ s[3],
               s[0]  ^ s[1]  ^ x2[2] ^ m3[3],
               m3[0] ^ s[1]  ^ s[2]  ^ x2[3]};
    inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    col_out = (mode == MODE_INV) ? inv_col : fwd_col;
  end

endmodule

// File: rtl/aes_mixcol_engine.sv
// Handshaked MixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock starting at column 0, and holds the
// result in an output register until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | transforming columns, one beat per clock
// DONE  | result presented; may accept the next block on handoff
module aes_mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_mode,
  output logic         busy
);

  localparam int NBEATS = 4 / COLS_PER_CYCLE;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mix_state_t  state;
  logic [31:0] work_cols [4];
  logic [31:0] res_cols  [4];
  logic        mode_q;
  logic        out_mode_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [BW-1:0] beat_cnt;
  logic        accept;
  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign busy      = busy_q;
  assign out_data  = {res_cols[0], res_cols[1], res_cols[2], res_cols[3]};

  // Column select for the current beat: columns beat*C .. beat*C+C-1.
  always_comb begin
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      col_idx[i] = 2'(int'(beat_cnt) * COLS_PER_CYCLE + i);
      col_in[i]  = work_cols[col_idx[i]];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    aes_mixcol_column u_col (
      .mode    (mode_q),
      .col_in  (col_in[g]),
      .col_out (col_out[g])
    );
  end

  // Engine FSM with registered handshake/status outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= MODE_FWD;
      out_mode_q  <= MODE_FWD;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      beat_cnt    <= '0;
      for (int k = 0; k < 4; k++) begin
        work_cols[k] <= '0;
        res_cols[k]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int k = 0; k < 4; k++) work_cols[k] <= in_data[127-32*k -: 32];
            mode_q   <= in_mode;
            beat_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < COLS_PER_CYCLE; i++) res_cols[col_idx[i]] <= col_out[i];
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt    <= '0;
            out_valid_q <= 1'b1;
            out_mode_q  <= mode_q;
            state       <= DONE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              // Handoff and next capture share this edge: no bubble.
              for (int k = 0; k < 4; k++) work_cols[k] <= in_data[127-32*k -: 32];
              mode_q   <= in_mode;
              beat_cnt <= '0;
              state    <= BUSY;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_mixcol_engine.md
# aes_mixcol_engine

Parametrised, handshaked MixColumns engine for the AES datapath, supporting both forward (encrypt) and inverse (decrypt) transforms with the direction selected per block. A 128-bit state is accepted over a valid/ready interface, processed COLS_PER_CYCLE columns per clock, and held in an output register until the consumer takes it. It sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round datapath, and lets area trade against latency.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data and in_mode are valid.
- in_ready  out  1  engine can accept a block.
- in_mode  in  1  0 = forward MixColumns, 1 = InvMixColumns.
- in_data  in  128  state. Column k is bits [127-32k : 96-32k]; byte a of each column is the MSB.
- out_valid  out  1  out_data and out_mode are valid.
- out_ready  in  1  consumer accepts the output.
- out_data  out  128  transformed state, with the same layout as in_data.
- out_mode  out  1  mode captured with this block.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Define N = 4/COLS_PER_CYCLE, giving beats per block.
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY on accept (in_valid && in_ready).
  - On accept, capture in_data into the work register and in_mode into the mode register, and clear beat_cnt.
- BUSY: each cycle, transform columns beat_cnt·C … beat_cnt·C+C−1, where C = COLS_PER_CYCLE, into the result register, then increment beat_cnt.
  - After beat N−1, go to DONE.
  - Columns are processed from column 0 upward.
- DONE: out_valid = 1.
  - If out_ready and no accept: go to IDLE.
  - If out_ready and accept in the same cycle: capture the new block and go to BUSY, giving back-to-back operation.
- in_ready = (state == IDLE) || (state == DONE && out_ready). in_ready is never high in BUSY.
- Forward column transform, in GF(2^8) modulo x^8+x^4+x^3+x+1:
  - a' = 2a⊕3b⊕c⊕d
  - b', c', d' are rotations of the same matrix.
- Inverse column transform: matrix rows {0e,0b,0d,09}, rotated per output byte.
- xtime(x) = {x[6:0],0} ⊕ (x[7] ? 8'h1b : 0). All arithmetic is 8-bit with no carries.
- out_data, out_mode and out_valid are registered. They remain stable while out_valid && !out_ready.
- Input values are ignored when in_ready is low.
- Reset values: state = IDLE, in_ready = 1 (reflecting IDLE after reset), out_valid = 0, out_data = 0, out_mode = 0, busy = 0, beat_cnt = 0.
- Reset asserted mid-block: the block is discarded and no output is produced. Reset release is synchronised externally.

## Timing
- Latency is N cycles from the accepting edge to out_valid high:
  - C = 4: 1 cycle.
  - C = 2: 2 cycles.
  - C = 1: 4 cycles.
- Throughput is one block per N+1 cycles when out_ready is held high. The DONE cycle overlaps the next accept.
- No combinational path exists from in_valid or in_data to any output. in_ready depends combinationally on out_ready only.
- Column datapath depth is at most 4 chained xtime stages plus XOR trees, and is single-cycle.

## Structure
- Shared package aes_pkg holds:
  - MODE_FWD = 1'b0 and MODE_INV = 1'b1.
  - The FSM state typedef {IDLE, BUSY, DONE}.
  - The xtime function.
  - The reduction constant 8'h1b.
- One sub-module, aes_mixcol_column, is a combinational 32-bit column transform with a mode input. It is instantiated COLS_PER_CYCLE times.
- Column select uses a beat_cnt-indexed mux. beat_cnt width is $clog2(N), with a minimum of 1 bit.

## Test plan
- C=1, fwd, column 0 = db135345, other columns = f20a225c, c6c6c6c6, d4d4d4d5 → out_data = 8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, out_valid high 4 cycles after the accept.
- C=4, inv, in_data = 8e4da1bc_9fdc589d_01010101_4d7ebdf8 → out_data = db135345_f20a225c_01010101_2d26314c, 1-cycle latency, out_mode = 1.
- C=2, fwd→inv round trip on 1000 random blocks → identity. Latency is exactly 2 cycles every time.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_data stable and in_ready = 0 throughout. Raising out_ready with in_valid high → new block accepted in the same cycle, with no bubble.
- Reset mid-BUSY (C=1, beat 2) → out_valid = 0, busy = 0, in_ready = 1 immediately. The next block then completes correctly.
- Mode switch between consecutive blocks (fwd, inv, fwd) with identical data → outputs match the golden model per block, and out_mode tracks each block.
